mem_arbiter_fsm: RTL and testbench
==================================

Name: mem_arbiter_fsm

Overview:
- Sequences the single shared multi-cycle main memory between the I-cache miss path and the D-cache miss/write path of the pipelined WISC CPU.
- On a miss, fetches a full cache block as pipelined word reads and streams the words into the requesting cache's fill port.
- D-side single-word writes are write-through.
- Sits between both cache controllers and the memory model.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- MEM_LAT, 4, cycles from read issue to mem_valid data return; memory accepts one read per cycle.
- BLK_WORDS, 8, words per cache block (16-byte block, word stride 2 bytes).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  I-cache miss request; level, held until i_done.
- i_addr  input  ADDR_W  I miss byte address.
- d_req  input  1  D-cache miss request; level, held until d_done.
- d_wr  input  1  qualifies d_req: 1 = single-word write, 0 = block fill.
- d_addr  input  ADDR_W  D byte address.
- d_wdata  input  DATA_W  D write data.
- mem_en  output  1  memory access strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory byte address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- mem_valid  input  1  mem_rdata valid.
- fill_we_i  output  1  write fill_data into the I-cache.
- fill_we_d  output  1  write fill_data into the D-cache.
- fill_idx  output  log2(BLK_WORDS)  word index within the block.
- fill_data  output  DATA_W  returned word.
- i_done  output  1  one-cycle pulse: I fill complete.
- d_done  output  1  one-cycle pulse: D fill or write complete.
- busy  output  1  FSM not IDLE.

Behaviour:
- Reset: state=IDLE, all counters 0, every output 0. Asynchronous on rst_n low; takes effect immediately, mid-operation included.
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: evaluate requests each cycle.
  - Priority: d_req over i_req (default; changed by the optional feature).
  - Grant registers the owner (I/D), op type, base address and write data.
  - d_req&d_wr -> WRITE. Any other granted request -> ISSUE.
  - Base address = addr & ~(2*BLK_WORDS-1).
- ISSUE: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, issue_cnt++ each cycle.
  - After issue_cnt reaches BLK_WORDS-1 is issued -> DRAIN.
  - Lasts exactly BLK_WORDS cycles.
- Returns are counted in ISSUE and DRAIN.
  - Each mem_valid: fill_data=mem_rdata, fill_idx=ret_cnt, fill_we_<owner>=1 (combinational, same cycle as mem_valid), ret_cnt++.
- DRAIN: mem_en=0. On the return with ret_cnt==BLK_WORDS-1, assert <owner>_done in the same cycle as the last fill_we -> IDLE.
- Fill timing: grant in IDLE at cycle 0; issues at cycles 1..BLK_WORDS; returns at cycles 1+MEM_LAT .. BLK_WORDS+MEM_LAT. With defaults: returns at cycles 5..12, done at 12.
- Next grant is possible at cycle 13, i.e. IDLE with the requester already deasserted. A requester must drop req the cycle after done.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=d_addr (unaligned word address kept), mem_wdata=d_wdata. d_done pulses the following cycle (in IDLE); no grant is issued in that cycle.
- mem_valid while in IDLE or WRITE is ignored: no fill_we, no counter change. This covers stale returns after a reset mid-fill.
- A requester deasserting req mid-fill does not abort; the fill completes and done still pulses.
- Both counters wrap only through reset or a new grant (cleared on grant).
- Only one transaction is outstanding at a time; the non-granted request waits with no timeout.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin priority. A 1-bit last_owner register resets to I, so D wins the first simultaneous request. Each grant goes to the requester not granted last when both request.
- Undefined: fixed D-over-I priority; the last_owner register is absent.

Test Plan:
- i_req, i_addr=0x1234, MEM_LAT=4:
  - mem_addr 0x1230,0x1232..0x123E on cycles 1-8.
  - fill_we_i with idx 0..7 on cycles 5-12.
  - i_done at cycle 12 only; fill_we_d never asserted.
- i_req and d_req (fill, d_addr=0x00A6) in the same cycle:
  - D fill of 0x00A0-0x00AE first, d_done at cycle 12.
  - I fill issues start at cycle 14.
- d_req, d_wr=1, d_addr=0x0042, d_wdata=0xBEEF:
  - One cycle of mem_en=mem_wr=1, addr 0x0042, data 0xBEEF.
  - d_done the next cycle; busy=0 afterwards.
- rst_n low at cycle 7 of an I fill, memory keeps returning valid data:
  - All outputs 0 immediately.
  - No fill_we or done from the stale returns.
  - A new d_req after reset fills normally.
- mem_valid=1 pulsed while IDLE -> no fill_we, and the counters are unchanged on the subsequent fill (idx starts at 0).
- With ARB_RR_EN, i_req and d_req both held continuously:
  - Grants alternate D, I, D.
  - Without the macro, D repeats while d_req is re-asserted.

Source files
------------

// File: rtl/mem_arbiter_fsm.sv
// Shared main-memory arbiter between the I-cache and D-cache miss paths: pipelined block fills and write-through single-word writes.
// Optional macro ARB_RR_EN selects round-robin priority; without it, D requests always win over I requests.
module mem_arbiter_fsm #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 4,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_valid,
    output logic                         fill_we_i,
    output logic                         fill_we_d,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]            fill_data,
    output logic                         i_done,
    output logic                         d_done,
    output logic                         busy
);

    localparam int                IDX_W    = $clog2(BLK_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLK_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * BLK_WORDS - 1);

    // Completion is only recognised in DRAIN, so at least one cycle of read latency is required.
    if (MEM_LAT < 1) begin : g_lat_check
        $error("mem_arbiter_fsm: MEM_LAT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [IDX_W-1:0]    issue_cnt;
    logic [IDX_W-1:0]    ret_cnt;
    logic                wr_done_q;

    logic                pick_d;
    logic                grant;
    logic                fill_hit;
    logic                last_ret;

`ifdef ARB_RR_EN
    owner_t              last_owner_q;

    // Under contention the requester that was not served last wins.
    assign pick_d = d_req & (~i_req | (last_owner_q == OWN_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_I;
        end else if (grant) begin
            last_owner_q <= pick_d ? OWN_D : OWN_I;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // The cycle after a write is reserved for its d_done pulse, so no grant is made then.
    assign grant    = (state_q == S_IDLE) & ~wr_done_q & (i_req | d_req);
    assign fill_hit = mem_valid & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
    assign last_ret = fill_hit & (state_q == S_DRAIN) & (ret_cnt == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = (pick_d & d_wr) ? S_WRITE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_cnt == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_ret) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            wr_done_q <= 1'b0;
        end else begin
            wr_done_q <= (state_q == S_WRITE);
            if (grant) begin
                owner_q   <= pick_d ? OWN_D : OWN_I;
                // Writes keep the exact word address; fills start at the block boundary.
                addr_q    <= (pick_d & d_wr) ? d_addr
                           : ((pick_d ? d_addr : i_addr) & ~OFF_MASK);
                wdata_q   <= d_wdata;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if ((state_q == S_ISSUE) && (issue_cnt != LAST_IDX)) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (fill_hit && (ret_cnt != LAST_IDX)) begin
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we_i = 1'b0;
        fill_we_d = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        i_done    = 1'b0;
        d_done    = wr_done_q;
        busy      = (state_q != S_IDLE);

        if (state_q == S_ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = addr_q + ADDR_W'({issue_cnt, 1'b0});
        end

        if (state_q == S_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end

        if (fill_hit) begin
            fill_we_i = (owner_q == OWN_I);
            fill_we_d = (owner_q == OWN_D);
            fill_idx  = ret_cnt;
            fill_data = mem_rdata;
        end

        if (last_ret) begin
            i_done = (owner_q == OWN_I);
            d_done = (owner_q == OWN_D);
        end
    end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed self-checking bench for mem_arbiter_fsm with a pipelined memory model (MEM_LAT cycles, data = addr ^ 0x5A5A).
// Define ARB_RR_EN for both bench and RTL to check the round-robin grant order.
module tb_mem_arbiter_fsm;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_LAT   = 4;
    localparam int BLK_WORDS = 8;

    logic              clk;
    logic              rst_n;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              fill_we_i;
    logic              fill_we_d;
    logic [2:0]        fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              busy;

    logic              inj_valid;
    logic [DATA_W-1:0] inj_data;

    int checks   = 0;
    int failures = 0;

    mem_arbiter_fsm #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .BLK_WORDS (BLK_WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .fill_we_i (fill_we_i),
        .fill_we_d (fill_we_d),
        .fill_idx  (fill_idx),
        .fill_data (fill_data),
        .i_done    (i_done),
        .d_done    (d_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one read accepted per cycle, returned MEM_LAT cycles after issue; never reset.
    logic [MEM_LAT-1:0] pipe_v = '0;
    logic [ADDR_W-1:0]  pipe_a [MEM_LAT];

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[MEM_LAT-2:0], mem_en & ~mem_wr};
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign mem_valid = pipe_v[MEM_LAT-1] | inj_valid;
    assign mem_rdata = pipe_v[MEM_LAT-1] ? (pipe_a[MEM_LAT-1] ^ 16'h5A5A) : inj_data;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic wr,
                              input logic [15:0] addr, input logic wei, input logic wed,
                              input logic [2:0] idx, input logic idn, input logic ddn,
                              input logic bsy);
        check({tag, "_mem_en"},    32'(mem_en),    32'(en));
        check({tag, "_mem_wr"},    32'(mem_wr),    32'(wr));
        check({tag, "_mem_addr"},  32'(mem_addr),  32'(addr));
        check({tag, "_fill_we_i"}, 32'(fill_we_i), 32'(wei));
        check({tag, "_fill_we_d"}, 32'(fill_we_d), 32'(wed));
        check({tag, "_fill_idx"},  32'(fill_idx),  32'(idx));
        check({tag, "_i_done"},    32'(i_done),    32'(idn));
        check({tag, "_d_done"},    32'(d_done),    32'(ddn));
        check({tag, "_busy"},      32'(busy),      32'(bsy));
    endtask

    // Called at mid-cycle 0 (grant cycle); checks cycles 1..13 and drops the request after done.
    task automatic check_fill(input bit is_d, input logic [15:0] addr);
        logic [15:0] base;
        logic        en;
        logic        we;
        logic [15:0] a;
        logic [2:0]  idx;
        string       tag;
        base = addr & 16'hFFF0;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            en  = (n >= 1) && (n <= 8);
            we  = (n >= 5) && (n <= 12);
            a   = en ? 16'(base + 2 * (n - 1)) : 16'h0000;
            idx = we ? 3'(n - 5) : 3'd0;
            tag = $sformatf("%s_%04h_c%0d", is_d ? "dfill" : "ifill", base, n);
            check_outs(tag, en, 1'b0, a, we & ~is_d, we & is_d, idx,
                       (n == 12) & ~is_d, (n == 12) & is_d, n <= 12);
            if (we) begin
                check({tag, "_fill_data"}, 32'(fill_data),
                      32'(16'(base + 2 * (n - 5)) ^ 16'h5A5A));
            end
            if (n == 12) begin
                if (is_d) d_req = 1'b0;
                else      i_req = 1'b0;
            end
        end
    endtask

    logic [2:0] owners;
    logic [2:0] exp_owners;
    int         n_done;

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b1;
        i_addr    = 16'h0000;
        d_req     = 1'b1;
        d_wr      = 1'b0;
        d_addr    = 16'h0000;
        d_wdata   = 16'h0000;
        inj_valid = 1'b1;
        inj_data  = 16'hFFFF;

        // Reset holds every output low even with requests and mem_valid present.
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("reset_fill_data", 32'(fill_data), 32'h0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'h0);
        inj_valid = 1'b0;
        i_req     = 1'b0;
        d_req     = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // I-cache block fill from an unaligned address.
        i_req  = 1'b1;
        i_addr = 16'h1234;
        check_fill(1'b0, 16'h1234);

        // Simultaneous requests: D fill first, then I fill granted the cycle D drops.
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h00A6;
        i_req  = 1'b1;
        i_addr = 16'h2010;
        check_fill(1'b1, 16'h00A6);
        check_fill(1'b0, 16'h2010);

        // Write-through single word; d_done follows one cycle later with no grant in that cycle.
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0042;
        d_wdata = 16'hBEEF;
        @(negedge clk);
        check_outs("wr_c1", 1'b1, 1'b1, 16'h0042, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check("wr_c1_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        check_outs("wr_c2", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        d_req = 1'b0;
        d_wr  = 1'b0;
        @(negedge clk);
        check_outs("wr_c3", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Stray mem_valid in IDLE produces no fill strobe, and the next fill still starts at index 0.
        inj_valid = 1'b1;
        inj_data  = 16'h1111;
        #1;
        check_outs("idle_valid", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        inj_valid = 1'b0;
        d_req     = 1'b1;
        d_addr    = 16'h00A6;
        check_fill(1'b1, 16'h00A6);

        // Reset at cycle 7 of an I fill; the memory keeps returning the in-flight reads.
        i_req  = 1'b1;
        i_addr = 16'h1234;
        repeat (7) @(negedge clk);
        check("pre_rst_mem_addr", 32'(mem_addr), 32'h123C);
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b0;
        for (int n = 8; n <= 12; n++) begin
            check_outs($sformatf("stale_c%0d", n), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0,
                       1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h00C8;
        check_fill(1'b1, 16'h00C8);

        // Both requesters held continuously from a fresh reset: record the owner of three completions.
        rst_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        i_req  = 1'b1;
        i_addr = 16'h1234;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h00A6;
        owners = 3'b000;
        n_done = 0;
        for (int c = 0; c < 80 && n_done < 3; c++) begin
            @(negedge clk);
            if (d_done) begin
                owners[n_done] = 1'b1;
                n_done++;
            end else if (i_done) begin
                owners[n_done] = 1'b0;
                n_done++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
`ifdef ARB_RR_EN
        exp_owners = 3'b101;
`else
        exp_owners = 3'b111;
`endif
        check("arb_done_count", 32'(n_done), 32'd3);
        check("arb_owner_0", 32'(owners[0]), 32'(exp_owners[0]));
        check("arb_owner_1", 32'(owners[1]), 32'(exp_owners[1]));
        check("arb_owner_2", 32'(owners[2]), 32'(exp_owners[2]));
        @(negedge clk);
        @(negedge clk);
        check("arb_busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
